// File: rtl/empaquetador_producto_flotante_if.sv
// Operand-set and packed-result bus for the FP product packer.
// The upstream multiplier and downstream consumer share this single bundle.
interface empaquetador_producto_flotante_if #(
    parameter int unsigned EW = 7,
    parameter int unsigned MW = 8,
    parameter int unsigned CW = 8
);
    logic              i_valid;
    logic              o_ready;
    logic              i_signo_1;
    logic              i_signo_2;
    logic [EW-1:0]     i_exponente_1;
    logic [EW-1:0]     i_exponente_2;
    logic [MW-1:0]     i_mantiza;
    logic              i_aviso_exponente;
    logic              o_valid;
    logic              i_ready;
    logic [EW+MW:0]    o_resultado;
    logic              o_overflow;
    logic              o_underflow;
    logic              i_clr_cnt;
    logic [CW-1:0]     o_cnt_overflow;
    logic [CW-1:0]     o_cnt_underflow;

    modport slave (
        input  i_valid, i_signo_1, i_signo_2, i_exponente_1, i_exponente_2,
               i_mantiza, i_aviso_exponente, i_ready, i_clr_cnt,
        output o_ready, o_valid, o_resultado, o_overflow, o_underflow,
               o_cnt_overflow, o_cnt_underflow
    );

    modport master (
        output i_valid, i_signo_1, i_signo_2, i_exponente_1, i_exponente_2,
               i_mantiza, i_aviso_exponente, i_ready, i_clr_cnt,
        input  o_ready, o_valid, o_resultado, o_overflow, o_underflow,
               o_cnt_overflow, o_cnt_underflow
    );
endinterface

// File: rtl/empaquetador_producto_flotante.sv
// FP multiply back end: biased exponent sum, zero/overflow/underflow classification
// and {sign, exp, mant} packing in a 2-stage valid/ready pipeline with event counters.
module empaquetador_producto_flotante #(
    parameter int unsigned EW   = 7,
    parameter int unsigned MW   = 8,
    parameter int unsigned BIAS = 63,
    parameter int unsigned CW   = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    empaquetador_producto_flotante_if.slave bus
);
    localparam int unsigned SW = EW + 2;
    localparam logic [SW-2:0] SUM_MAX = (SW-1)'((1 << EW) - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Stage 1 state
    logic          v1;
    logic          sign1;
    logic          zero1;
    logic [MW-1:0] mant1;
    logic [SW-1:0] sum1;

    // Stage 2 state (drives the output bus)
    logic             v2;
    logic [EW+MW:0]   resultado;
    logic             overflow;
    logic             underflow;
    logic [CW-1:0]    cnt_overflow;
    logic [CW-1:0]    cnt_underflow;

    logic          adv1, adv2, xfer_out;
    logic [SW-1:0] sum_c;
    logic          is_ovf_c, is_unf_c;
    logic [EW+MW:0] res_c;

    assign adv2     = !v2 || bus.i_ready;
    assign adv1     = !v1 || adv2;
    assign xfer_out = v2 && bus.i_ready;

    assign bus.o_ready         = adv1 && i_rst_n;
    assign bus.o_valid         = v2;
    assign bus.o_resultado     = resultado;
    assign bus.o_overflow      = overflow;
    assign bus.o_underflow     = underflow;
    assign bus.o_cnt_overflow  = cnt_overflow;
    assign bus.o_cnt_underflow = cnt_underflow;

    // Full-width signed sum; SW bits hold every e1+e2+aviso-BIAS without wrap
    assign sum_c = SW'(bus.i_exponente_1) + SW'(bus.i_exponente_2)
                 + SW'(bus.i_aviso_exponente) - SW'(BIAS);

    // Classification of the stage-1 sum, zero operand taking priority
    always_comb begin
        is_ovf_c = 1'b0;
        is_unf_c = 1'b0;
        res_c    = '0;
        if (zero1) begin
            res_c = {sign1, EW'(0), MW'(0)};
        end else if (!sum1[SW-1] && (sum1[SW-2:0] >= SUM_MAX)) begin
            is_ovf_c = 1'b1;
            res_c    = {sign1, {EW{1'b1}}, MW'(0)};
        end else if (sum1[SW-1] || (sum1 == '0)) begin
            is_unf_c = 1'b1;
            res_c    = {sign1, EW'(0), MW'(0)};
        end else begin
            res_c = {sign1, sum1[EW-1:0], mant1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            zero1 <= 1'b0;
            mant1 <= '0;
            sum1  <= '0;
        end else if (adv1) begin
            v1 <= bus.i_valid;
            if (bus.i_valid) begin
                sign1 <= bus.i_signo_1 ^ bus.i_signo_2;
                zero1 <= (bus.i_exponente_1 == '0) || (bus.i_exponente_2 == '0);
                mant1 <= bus.i_mantiza;
                sum1  <= sum_c;
            end
        end
    end

    // Flags follow v2 so they read 0 whenever the output is idle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v2        <= 1'b0;
            resultado <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (adv2) begin
            v2        <= v1;
            overflow  <= v1 && is_ovf_c;
            underflow <= v1 && is_unf_c;
            if (v1) begin
                resultado <= res_c;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_clr_cnt) begin
            cnt_overflow  <= '0;
            cnt_underflow <= '0;
        end else if (xfer_out) begin
            if (overflow && (cnt_overflow != CNT_MAX)) begin
                cnt_overflow <= cnt_overflow + CW'(1);
            end
            if (underflow && (cnt_underflow != CNT_MAX)) begin
                cnt_underflow <= cnt_underflow + CW'(1);
            end
        end
    end
endmodule
